reg_file_bank: RTL and testbench
================================

Name: reg_file_bank

Overview:
- Register-file stage built on the datapath's funsel-controlled register cell.
- Holds 4 general-purpose registers (R1-R4) and 4 temporary registers (T1-T4), each NBITS wide.
- Applies one funsel operation per clock to every selected register.
- Drives two independent combinational read ports (OutA, OutB) into the ALU operand muxes.

Parameters:
NBITS, 16, width of every register, of the data input and of both read ports

Ports:
clk        input   1      system clock; all register updates on rising edge
rst_n      input   1      asynchronous active-low reset
i          input   NBITS  write data for load operations
funsel     input   2      operation: 00 clear, 01 load, 10 decrement, 11 increment
rsel       input   4      per-register enable for R1..R4; bit3=R1, bit2=R2, bit1=R3, bit0=R4
tsel       input   4      per-register enable for T1..T4; bit3=T1, bit2=T2, bit1=T3, bit0=T4
out_a_sel  input   3      read select A: 000 T1, 001 T2, 010 T3, 011 T4, 100 R1, 101 R2, 110 R3, 111 R4
out_b_sel  input   3      read select B, same encoding as out_a_sel
out_a      output  NBITS  contents of register chosen by out_a_sel
out_b      output  NBITS  contents of register chosen by out_b_sel

Behaviour:
- Reset: rst_n low forces all 8 registers to 0 immediately, regardless of clk; out_a = out_b = 0 while held.
  - Release is synchronous-safe: first update occurs on the first rising clk edge with rst_n high.
- Update: on rising clk, each register whose rsel/tsel bit is 1 takes the funsel operation:
  - 00: value becomes 0
  - 01: value becomes i
  - 10: value becomes value-1, modulo 2^NBITS
  - 11: value becomes value+1, modulo 2^NBITS
- Unselected registers hold their value.
- Enables of all zero means no register changes; funsel is then don't-care.
- Multiple enables set: all selected registers perform the same op in the same cycle.
  - Each inc/dec uses that register's own old value; a load writes the same i into all selected registers.
- Wrap-around (default build): increment of all-ones gives 0; decrement of 0 gives all-ones.
- Read ports: purely combinational from register state; no read latency. A and B may select the same register.
- Write latency is 1 cycle.
  - When a register is written in cycle N and read in the same cycle, the port shows the old value until the edge, then the new value. There is no write-to-read bypass.
- Reset mid-operation: asserting rst_n overrides any pending op; the edge coincident with reset does not update.
- There are no X-producing states; every encoding of every select is defined.

Optional Feature:
- Macro: RF_SATURATE_EN.
- Defined:
  - increment of a register at all-ones leaves it at all-ones
  - decrement of a register at 0 leaves it at 0
  - clear, load and the other cases are unchanged
- Undefined: modulo wrap-around as stated in Behaviour.
- Ports and latency are identical in both builds.

Test Plan:
1. Reset: drive rst_n=0 mid-cycle after loading R1=0x1234 -> out_a (sel 100) = 0x0000 without waiting for clk; hold 2 edges, still 0.
2. Load/read: i=0xBEEF, funsel=01, rsel=1000 for one edge, then i=0x0102, tsel=0010 -> R1=0xBEEF, T3=0x0102. Check with out_a_sel=100, out_b_sel=010; unselected registers remain 0.
3. Multi-select inc: R1=0x0005, R2=0x0010, rsel=1100, funsel=11, 3 edges -> R1=0x0008, R2=0x0013; R3 and R4 unchanged.
4. Wrap/saturate:
   - T4=0xFFFF, tsel=0001, funsel=11, one edge -> T4=0x0000 (default) or 0xFFFF (RF_SATURATE_EN).
   - T4=0x0000, funsel=10 -> 0xFFFF (default) or 0x0000 (RF_SATURATE_EN).
5. Read-during-write: R2=0x00AA, out_a_sel=101, load i=0x5555 into R2 -> out_a stays 0x00AA until the edge, then 0x5555 in the same cycle as the edge. out_b_sel=101 tracks identically.
6. Clear and idle: funsel=00 with rsel=1111, tsel=1111 -> all 8 registers read 0. Then rsel=tsel=0000 with funsel=01, i=0xFFFF for 4 edges -> all remain 0.

Source files
------------

// File: rtl/reg_file_bank.sv
// rtl/reg_file_bank.sv - eight funsel-controlled registers (R1-R4, T1-T4) with two combinational read ports
// Optional build macro: RF_SATURATE_EN (inc/dec saturate instead of wrapping)

module reg_file_cell #(
  parameter int NBITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       funsel,
  input  logic [NBITS-1:0] d,
  output logic [NBITS-1:0] q
);

  localparam logic [1:0] FS_CLEAR = 2'b00;
  localparam logic [1:0] FS_LOAD  = 2'b01;
  localparam logic [1:0] FS_DEC   = 2'b10;
  localparam logic [1:0] FS_INC   = 2'b11;

  localparam logic [NBITS-1:0] ALL_ONES = {NBITS{1'b1}};
  localparam logic [NBITS-1:0] ZERO     = {NBITS{1'b0}};
  localparam logic [NBITS-1:0] ONE      = {{(NBITS-1){1'b0}}, 1'b1};

  logic [NBITS-1:0] q_next;

  // Next value for this register when enabled; inc/dec use only this register's own old value.
  always_comb begin
    q_next = q;
    unique case (funsel)
      FS_CLEAR: q_next = ZERO;
      FS_LOAD:  q_next = d;
`ifdef RF_SATURATE_EN
      FS_DEC:   q_next = (q == ZERO) ? ZERO : q - ONE;
      FS_INC:   q_next = (q == ALL_ONES) ? ALL_ONES : q + ONE;
`else
      FS_DEC:   q_next = q - ONE;
      FS_INC:   q_next = q + ONE;
`endif
      default:  q_next = q;
    endcase
  end

  // State register: async clear dominates, otherwise update only when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= ZERO;
    end else if (en) begin
      q <= q_next;
    end
  end

endmodule

module reg_file_bank #(
  parameter int NBITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] i,
  input  logic [1:0]       funsel,
  input  logic [3:0]       rsel,
  input  logic [3:0]       tsel,
  input  logic [2:0]       out_a_sel,
  input  logic [2:0]       out_b_sel,
  output logic [NBITS-1:0] out_a,
  output logic [NBITS-1:0] out_b
);

  // Register slots are ordered by read-select code: 0..3 = T1..T4, 4..7 = R1..R4.
  logic [7:0]       en_vec;
  logic [NBITS-1:0] regs [8];

  // Enable bit 3 of each select names the lowest-numbered register, so the bits are reversed here.
  assign en_vec = {rsel[0], rsel[1], rsel[2], rsel[3],
                   tsel[0], tsel[1], tsel[2], tsel[3]};

  for (genvar g = 0; g < 8; g++) begin : g_cell
    reg_file_cell #(.NBITS(NBITS)) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en_vec[g]),
      .funsel (funsel),
      .d      (i),
      .q      (regs[g])
    );
  end

  // Read port A: straight mux off register state, no bypass from the pending write.
  always_comb begin
    out_a = regs[out_a_sel];
  end

  // Read port B: independent mux, may select the same register as port A.
  always_comb begin
    out_b = regs[out_b_sel];
  end

endmodule

// File: tb/tb_reg_file_bank.sv
// tb/tb_reg_file_bank.sv - directed plus randomized check of reg_file_bank against a behavioural model
`timescale 1ns/1ns

module tb_reg_file_bank;

  localparam int NBITS = 16;

  logic             clk;
  logic             rst_n;
  logic [NBITS-1:0] i;
  logic [1:0]       funsel;
  logic [3:0]       rsel;
  logic [3:0]       tsel;
  logic [2:0]       out_a_sel;
  logic [2:0]       out_b_sel;
  logic [NBITS-1:0] out_a;
  logic [NBITS-1:0] out_b;

  int tests;
  int fails;

  // Reference contents indexed by read-select code: 0..3 = T1..T4, 4..7 = R1..R4.
  int unsigned model [8];

  reg_file_bank #(.NBITS(NBITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i         (i),
    .funsel    (funsel),
    .rsel      (rsel),
    .tsel      (tsel),
    .out_a_sel (out_a_sel),
    .out_b_sel (out_b_sel),
    .out_a     (out_a),
    .out_b     (out_b)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [NBITS-1:0] obs, input logic [NBITS-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit selected(input int idx, input logic [3:0] r, input logic [3:0] t);
    if (idx < 4) return t[3-idx];
    return r[7-idx];
  endfunction

  // Apply one clock's worth of the funsel rule to the model, using the current inputs.
  function automatic void model_edge();
    int unsigned mx;
    mx = (1 << NBITS) - 1;
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) model[k] = 0;
      return;
    end
    for (int k = 0; k < 8; k++) begin
      if (selected(k, rsel, tsel)) begin
        case (funsel)
          2'b00: model[k] = 0;
          2'b01: model[k] = i;
`ifdef RF_SATURATE_EN
          2'b10: model[k] = (model[k] == 0) ? 0 : model[k] - 1;
          2'b11: model[k] = (model[k] == mx) ? mx : model[k] + 1;
`else
          2'b10: model[k] = (model[k] + mx) % (mx + 1);
          2'b11: model[k] = (model[k] + 1) % (mx + 1);
`endif
          default: ;
        endcase
      end
    end
  endfunction

  // One rising edge, then park at the falling edge where outputs are sampled and inputs changed.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rsel = 4'b0000;
    tsel = 4'b0000;
    funsel = 2'b00;
    i = '0;
  endtask

  // Sweep both read ports over every register and compare with the model.
  task automatic check_all(input string tag);
    for (int k = 0; k < 8; k++) begin
      out_a_sel = 3'(k);
      out_b_sel = 3'(7 - k);
      #1;
      check($sformatf("%s_a%0d", tag, k), out_a, NBITS'(model[k]));
      check($sformatf("%s_b%0d", tag, 7 - k), out_b, NBITS'(model[7 - k]));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int k = 0; k < 8; k++) model[k] = 0;
    rst_n = 1'b0;
    idle_inputs();
    out_a_sel = 3'b000;
    out_b_sel = 3'b000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_all("reset_state");

    // Plan 1: async reset clears R1 without a clock edge, and holds across edges.
    i = 16'h1234; funsel = 2'b01; rsel = 4'b1000;
    tick();
    idle_inputs();
    out_a_sel = 3'b100;
    #1;
    check("r1_loaded", out_a, 16'h1234);
    #5;
    rst_n = 1'b0;
    for (int k = 0; k < 8; k++) model[k] = 0;
    #1;
    check("async_reset_now", out_a, 16'h0000);
    i = 16'hFFFF; funsel = 2'b01; rsel = 4'b1111; tsel = 4'b1111;
    tick();
    tick();
    check("reset_held_2edges", out_a, 16'h0000);
    idle_inputs();
    rst_n = 1'b1;
    tick();
    check_all("after_reset");

    // Plan 2: load R1 and T3, others stay zero.
    i = 16'hBEEF; funsel = 2'b01; rsel = 4'b1000;
    tick();
    idle_inputs();
    i = 16'h0102; funsel = 2'b01; tsel = 4'b0010;
    tick();
    idle_inputs();
    out_a_sel = 3'b100; out_b_sel = 3'b010;
    #1;
    check("load_r1", out_a, 16'hBEEF);
    check("load_t3", out_b, 16'h0102);
    check_all("load");

    // Plan 3: two registers increment together from different start values.
    i = 16'h0005; funsel = 2'b01; rsel = 4'b1000; tick();
    i = 16'h0010; rsel = 4'b0100; tick();
    idle_inputs();
    funsel = 2'b11; rsel = 4'b1100;
    repeat (3) tick();
    idle_inputs();
    out_a_sel = 3'b100; out_b_sel = 3'b101;
    #1;
    check("inc3_r1", out_a, 16'h0008);
    check("inc3_r2", out_b, 16'h0013);
    check_all("multi_inc");

    // Plan 4: boundary inc of all-ones and dec of zero on T4.
    i = 16'hFFFF; funsel = 2'b01; tsel = 4'b0001; tick();
    funsel = 2'b11; tick();
    idle_inputs();
    out_a_sel = 3'b011;
    #1;
`ifdef RF_SATURATE_EN
    check("t4_inc_top", out_a, 16'hFFFF);
`else
    check("t4_inc_top", out_a, 16'h0000);
`endif
    i = 16'h0000; funsel = 2'b01; tsel = 4'b0001; tick();
    funsel = 2'b10; tick();
    idle_inputs();
    #1;
`ifdef RF_SATURATE_EN
    check("t4_dec_zero", out_a, 16'h0000);
`else
    check("t4_dec_zero", out_a, 16'hFFFF);
`endif

    // Plan 5: read during write shows old value until the edge.
    i = 16'h00AA; funsel = 2'b01; rsel = 4'b0100; tick();
    out_a_sel = 3'b101; out_b_sel = 3'b101;
    i = 16'h5555; funsel = 2'b01; rsel = 4'b0100;
    #1;
    check("rdw_a_before", out_a, 16'h00AA);
    check("rdw_b_before", out_b, 16'h00AA);
    @(posedge clk);
    model_edge();
    #1;
    check("rdw_a_after", out_a, 16'h5555);
    check("rdw_b_after", out_b, 16'h5555);
    @(negedge clk);
    idle_inputs();

    // Plan 6: clear everything, then idle cycles with load op but no enables.
    funsel = 2'b00; rsel = 4'b1111; tsel = 4'b1111; tick();
    idle_inputs();
    for (int k = 0; k < 8; k++) check_all_zero_guard: begin end
    check_all("clear_all");
    i = 16'hFFFF; funsel = 2'b01;
    repeat (4) tick();
    idle_inputs();
    check_all("idle_no_change");

    // Randomized traffic with occasional mid-cycle async resets.
    for (int n = 0; n < 300; n++) begin
      i = NBITS'($urandom);
      funsel = 2'($urandom);
      rsel = 4'($urandom);
      tsel = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        i = (($urandom & 1) != 0) ? {NBITS{1'b1}} : '0;
      end
      out_a_sel = 3'($urandom);
      out_b_sel = 3'($urandom);
      #1;
      check("rand_pre_a", out_a, NBITS'(model[out_a_sel]));
      check("rand_pre_b", out_b, NBITS'(model[out_b_sel]));
      if ($urandom_range(0, 39) == 0) begin
        #3;
        rst_n = 1'b0;
        for (int k = 0; k < 8; k++) model[k] = 0;
        #1;
        check("rand_async_rst", out_a, 16'h0000);
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
      #1;
      check("rand_post_a", out_a, NBITS'(model[out_a_sel]));
      check("rand_post_b", out_b, NBITS'(model[out_b_sel]));
    end
    idle_inputs();
    check_all("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
